lif_neuron_bank: RTL and testbench

- Downstream consumer of the CSR sparse MVM engine: receives the 4 per-row dot-product results it streams out and integrates them into 4 leaky integrate-and-fire neurons.
- After each complete 4-value frame, the block updates every membrane potential and produces a 4-bit spike vector.
- The spike vector is the next-timestep spike train that the CPU or loop-back logic returns to the MVM engine.

---
 rtl/lif_pkg.sv | 27 ++
 rtl/lif_neuron_bank_if.sv | 31 +++
 rtl/lif_update.sv | 33 +++
 rtl/lif_neuron_bank.sv | 140 ++++++++++++++
 tb/tb_lif_neuron_bank.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lif_pkg.sv
// Shared definitions for the leaky integrate-and-fire neuron bank.
//   - lif_state_e : bank sequencing states (COLLECT, UPDATE, EMIT)
//   - LIF_*       : default bank geometry and neuron constants
//   - sat_add     : add two non-negative values, clamped to max_val
package lif_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        UPDATE  = 2'd1,
        EMIT    = 2'd2
    } lif_state_e;

    localparam int LIF_N          = 4;
    localparam int LIF_VW         = 8;
    localparam int LIF_MW         = 10;
    localparam int LIF_THRESH     = 200;
    localparam int LIF_LEAK_SHIFT = 3;

    // Operands are small non-negative magnitudes, so a 32-bit signed sum
    // cannot wrap and the clamp alone decides saturation.
    function automatic int sat_add(input int a, input int b, input int max_val);
        int sum;
        sum = a + b;
        return (sum > max_val) ? max_val : sum;
    endfunction

endpackage

// File: rtl/lif_neuron_bank_if.sv
// Stream/result bundle between the MVM engine side and the neuron bank.
//   in_val      : MVM row result, valid when in_toggle changes
//   in_toggle   : toggle-encoded strobe, each edge is one new in_val
//   frame_clr   : resync, restarts frame collection
//   spike_out   : spike vector of the last completed frame
//   spike_valid : one-cycle pulse when spike_out updates
//   busy        : bank is updating or emitting and cannot accept values
//   overrun     : sticky, a value arrived while busy
// master = producer/consumer around the bank, slave = the bank itself.
interface lif_neuron_bank_if #(
    parameter int N  = 4,
    parameter int VW = 8
);
    logic [VW-1:0] in_val;
    logic          in_toggle;
    logic          frame_clr;
    logic [N-1:0]  spike_out;
    logic          spike_valid;
    logic          busy;
    logic          overrun;

    modport master (
        output in_val, in_toggle, frame_clr,
        input  spike_out, spike_valid, busy, overrun
    );

    modport slave (
        input  in_val, in_toggle, frame_clr,
        output spike_out, spike_valid, busy, overrun
    );
endinterface

// File: rtl/lif_update.sv
// Combinational single-neuron leaky integrate-and-fire step.
//   v      : current membrane potential (MW bits, unsigned)
//   in_val : input current for this frame (VW bits, zero-extended)
//   v_next : new membrane potential (0 after a spike)
//   spike  : neuron fires this frame
module lif_update
    import lif_pkg::*;
#(
    parameter int VW         = LIF_VW,
    parameter int MW         = LIF_MW,
    parameter int THRESH     = LIF_THRESH,
    parameter int LEAK_SHIFT = LIF_LEAK_SHIFT
) (
    input  logic [MW-1:0] v,
    input  logic [VW-1:0] in_val,
    output logic [MW-1:0] v_next,
    output logic          spike
);
    localparam int V_MAX = (1 << MW) - 1;

    logic [MW-1:0] leaked;
    int            t;

    // v - (v >> s) never underflows, so the leak alone keeps v >= 0.
    // The sum is done wide and clamped so overflow saturates instead of wrapping.
    always_comb begin
        leaked = v - (v >> LEAK_SHIFT);
        t      = sat_add(int'(leaked), int'(in_val), V_MAX);
        spike  = (t >= THRESH);
        v_next = spike ? '0 : MW'(t);
    end

endmodule

// File: rtl/lif_neuron_bank.sv
// Bank of N leaky integrate-and-fire neurons fed by the sparse MVM engine.
// Collects one N-value frame from a toggle-encoded stream, then updates
// each neuron in turn with a single shared lif_update, then publishes the
// spike vector.
//   clk   : clock
//   rst_n : asynchronous reset, active high
//   bus   : lif_neuron_bank_if slave (stream in, spikes/status out)
module lif_neuron_bank
    import lif_pkg::*;
#(
    parameter int N          = LIF_N,
    parameter int VW         = LIF_VW,
    parameter int MW         = LIF_MW,
    parameter int THRESH     = LIF_THRESH,
    parameter int LEAK_SHIFT = LIF_LEAK_SHIFT
) (
    input  logic               clk,
    input  logic               rst_n,
    lif_neuron_bank_if.slave   bus
);
    localparam int            IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    lif_state_e    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          toggle_q, toggle_d;
    logic [MW-1:0] v_q [N];
    logic [MW-1:0] v_d [N];
    logic [VW-1:0] in_buf_q [N];
    logic [VW-1:0] in_buf_d [N];
    logic [N-1:0]  spk_q, spk_d;
    logic [N-1:0]  spike_out_q, spike_out_d;
    logic          spike_valid_q, spike_valid_d;
    logic          overrun_q, overrun_d;

    logic          strb;
    logic [MW-1:0] upd_v_next;
    logic          upd_spike;

    assign strb = bus.in_toggle ^ toggle_q;

    // idx doubles as the value slot in COLLECT and the neuron index in UPDATE.
    lif_update #(
        .VW         (VW),
        .MW         (MW),
        .THRESH     (THRESH),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_update (
        .v      (v_q[idx_q]),
        .in_val (in_buf_q[idx_q]),
        .v_next (upd_v_next),
        .spike  (upd_spike)
    );

    // The spike vector and its valid pulse are registered on the last UPDATE
    // cycle so that they are visible exactly during the EMIT cycle.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        toggle_d      = bus.in_toggle;
        v_d           = v_q;
        in_buf_d      = in_buf_q;
        spk_d         = spk_q;
        spike_out_d   = spike_out_q;
        spike_valid_d = 1'b0;
        overrun_d     = overrun_q;

        if (bus.frame_clr) begin
            // Strobe in the same cycle is ignored entirely; membranes are kept.
            idx_d   = '0;
            state_d = COLLECT;
        end else begin
            if (strb && (state_q != COLLECT)) begin
                overrun_d = 1'b1;
            end

            case (state_q)
                COLLECT: begin
                    if (strb) begin
                        in_buf_d[idx_q] = bus.in_val;
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            state_d = UPDATE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                UPDATE: begin
                    v_d[idx_q]   = upd_v_next;
                    spk_d[idx_q] = upd_spike;
                    if (idx_q == LAST_IDX) begin
                        idx_d         = '0;
                        state_d       = EMIT;
                        spike_out_d   = spk_d;
                        spike_valid_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                EMIT: begin
                    state_d = COLLECT;
                end
                default: begin
                    state_d = COLLECT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q       <= COLLECT;
            idx_q         <= '0;
            toggle_q      <= 1'b0;
            v_q           <= '{default: '0};
            in_buf_q      <= '{default: '0};
            spk_q         <= '0;
            spike_out_q   <= '0;
            spike_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            toggle_q      <= toggle_d;
            v_q           <= v_d;
            in_buf_q      <= in_buf_d;
            spk_q         <= spk_d;
            spike_out_q   <= spike_out_d;
            spike_valid_q <= spike_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign bus.spike_out   = spike_out_q;
    assign bus.spike_valid = spike_valid_q;
    assign bus.busy        = (state_q != COLLECT);
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_lif_neuron_bank.sv
// Self-checking bench for lif_neuron_bank.
// Three banks share in_val/frame_clr/reset but have separate toggle strobes:
//   dut_a : default THRESH=200
//   dut_b : THRESH=1023 (saturation case)
//   dut_c : THRESH=0 (always fires)
module tb_lif_neuron_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_val;
    logic       frame_clr;
    logic [2:0] tog;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lif_neuron_bank_if #(.N(4), .VW(8)) bus_a ();
    lif_neuron_bank_if #(.N(4), .VW(8)) bus_b ();
    lif_neuron_bank_if #(.N(4), .VW(8)) bus_c ();

    assign bus_a.in_val    = in_val;
    assign bus_b.in_val    = in_val;
    assign bus_c.in_val    = in_val;
    assign bus_a.frame_clr = frame_clr;
    assign bus_b.frame_clr = frame_clr;
    assign bus_c.frame_clr = frame_clr;
    assign bus_a.in_toggle = tog[0];
    assign bus_b.in_toggle = tog[1];
    assign bus_c.in_toggle = tog[2];

    lif_neuron_bank #(.N(4), .VW(8), .MW(10), .THRESH(200), .LEAK_SHIFT(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );
    lif_neuron_bank #(.N(4), .VW(8), .MW(10), .THRESH(1023), .LEAK_SHIFT(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );
    lif_neuron_bank #(.N(4), .VW(8), .MW(10), .THRESH(0), .LEAK_SHIFT(3)) dut_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_c)
    );

    typedef struct {
        int          sel;
        logic [31:0] vals;
        logic [3:0]  exp_spk;
        logic [39:0] exp_v;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input int sel, input int a, input int b, input int c, input int d,
                                input logic [3:0] spk,
                                input int v0, input int v1, input int v2, input int v3);
        vec_t r;
        r.sel     = sel;
        r.vals    = {8'(d), 8'(c), 8'(b), 8'(a)};
        r.exp_spk = spk;
        r.exp_v   = {10'(v3), 10'(v2), 10'(v1), 10'(v0)};
        return r;
    endfunction

    function automatic logic get_valid(input int sel);
        case (sel)
            0:       return bus_a.spike_valid;
            1:       return bus_b.spike_valid;
            default: return bus_c.spike_valid;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return bus_a.busy;
            1:       return bus_b.busy;
            default: return bus_c.busy;
        endcase
    endfunction

    function automatic logic get_overrun(input int sel);
        case (sel)
            0:       return bus_a.overrun;
            1:       return bus_b.overrun;
            default: return bus_c.overrun;
        endcase
    endfunction

    function automatic logic [3:0] get_spk(input int sel);
        case (sel)
            0:       return bus_a.spike_out;
            1:       return bus_b.spike_out;
            default: return bus_c.spike_out;
        endcase
    endfunction

    function automatic logic [9:0] get_v(input int sel, input int k);
        case (sel)
            0:       return dut_a.v_q[k];
            1:       return dut_b.v_q[k];
            default: return dut_c.v_q[k];
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic send_val(input int sel, input logic [7:0] v);
        in_val = v;
        case (sel)
            0:       tog[0] = ~tog[0];
            1:       tog[1] = ~tog[1];
            default: tog[2] = ~tog[2];
        endcase
        tick();
    endtask

    task automatic wait_valid(input int sel, output int n);
        n = 0;
        while ((get_valid(sel) !== 1'b1) && (n < 20)) begin
            tick();
            n++;
        end
        checkOutput("valid_seen", 32'(get_valid(sel)), 32'd1);
    endtask

    // Sends values first..3 of the vector, then checks latency, spikes and membranes.
    task automatic applyStimulus(input vec_t vec, input int first, input string tag);
        int n;
        for (int k = first; k < 4; k++) begin
            send_val(vec.sel, vec.vals[8*k +: 8]);
        end
        checkOutput($sformatf("%s_busy", tag), 32'(get_busy(vec.sel)), 32'd1);
        wait_valid(vec.sel, n);
        checkOutput($sformatf("%s_latency", tag), 32'(n), 32'd4);
        checkOutput($sformatf("%s_spk", tag), 32'(get_spk(vec.sel)), 32'(vec.exp_spk));
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("%s_v%0d", tag, k), 32'(get_v(vec.sel, k)), 32'(vec.exp_v[10*k +: 10]));
        end
        tick();
        checkOutput($sformatf("%s_pulse_end", tag), 32'(get_valid(vec.sel)), 32'd0);
        checkOutput($sformatf("%s_idle", tag), 32'(get_busy(vec.sel)), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  n;
        logic seen;

        vecs[0]  = mk(0, 100,   0, 0,   0, 4'b0000, 100,   0, 0, 0);
        vecs[1]  = mk(0, 100,   0, 0,   0, 4'b0000, 188,   0, 0, 0);
        vecs[2]  = mk(0, 100,   0, 0,   0, 4'b0001,   0,   0, 0, 0);
        vecs[3]  = mk(0, 200, 199, 0, 255, 4'b1001,   0, 199, 0, 0);
        vecs[4]  = mk(0,   0,   0, 0,   0, 4'b0000,   0, 175, 0, 0);
        vecs[5]  = mk(0,   0,   0, 0,   0, 4'b0000,   0, 154, 0, 0);
        vecs[6]  = mk(1, 255,   0, 0,   0, 4'b0000, 255,   0, 0, 0);
        vecs[7]  = mk(1, 255,   0, 0,   0, 4'b0000, 479,   0, 0, 0);
        vecs[8]  = mk(1, 255,   0, 0,   0, 4'b0000, 675,   0, 0, 0);
        vecs[9]  = mk(1, 255,   0, 0,   0, 4'b0000, 846,   0, 0, 0);
        vecs[10] = mk(1, 255,   0, 0,   0, 4'b0000, 996,   0, 0, 0);
        vecs[11] = mk(1, 255,   0, 0,   0, 4'b0001,   0,   0, 0, 0);
        vecs[12] = mk(2,   5,   0, 0,   0, 4'b1111,   0,   0, 0, 0);
        vecs[13] = mk(2,   0,   0, 0,   0, 4'b1111,   0,   0, 0, 0);

        rst_n     = 1'b1;
        in_val    = '0;
        frame_clr = 1'b0;
        tog       = '0;
        #22;
        rst_n = 1'b0;
        tick();

        for (int s = 0; s < 3; s++) begin
            checkOutput($sformatf("rst%0d_spk", s), 32'(get_spk(s)), 32'd0);
            checkOutput($sformatf("rst%0d_valid", s), 32'(get_valid(s)), 32'd0);
            checkOutput($sformatf("rst%0d_busy", s), 32'(get_busy(s)), 32'd0);
            checkOutput($sformatf("rst%0d_overrun", s), 32'(get_overrun(s)), 32'd0);
        end

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i], 0, $sformatf("vec%0d", i));
        end

        // Fifth strobe lands while neuron 1 is being updated.
        for (int k = 0; k < 4; k++) begin
            send_val(0, 8'd0);
        end
        tick();
        send_val(0, 8'd250);
        checkOutput("ovr_flag", 32'(get_overrun(0)), 32'd1);
        checkOutput("ovr_busy", 32'(get_busy(0)), 32'd1);
        wait_valid(0, n);
        checkOutput("ovr_spk", 32'(get_spk(0)), 32'd0);
        checkOutput("ovr_v1", 32'(get_v(0, 1)), 32'd135);
        tick();
        applyStimulus(mk(0, 50, 0, 0, 0, 4'b0000, 50, 119, 0, 0), 0, "post_ovr");
        checkOutput("ovr_sticky", 32'(get_overrun(0)), 32'd1);

        // Partial frame aborted; the strobe coinciding with frame_clr is ignored.
        send_val(0, 8'd10);
        send_val(0, 8'd20);
        frame_clr = 1'b1;
        send_val(0, 8'd99);
        frame_clr = 1'b0;
        send_val(0, 8'd30);
        send_val(0, 8'd0);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (get_valid(0) || get_busy(0)) seen = 1'b1;
            tick();
        end
        checkOutput("clr_no_frame", 32'(seen), 32'd0);
        applyStimulus(mk(0, 30, 0, 0, 40, 4'b0000, 74, 105, 0, 40), 2, "post_clr");

        // Reset asserted after neurons 0 and 1 have been updated.
        for (int k = 0; k < 4; k++) begin
            send_val(0, 8'd20);
        end
        tick();
        tick();
        checkOutput("pre_rst_v0", 32'(get_v(0, 0)), 32'd85);
        rst_n = 1'b1;
        tog   = '0;
        #1;
        checkOutput("midrst_spk", 32'(get_spk(0)), 32'd0);
        checkOutput("midrst_valid", 32'(get_valid(0)), 32'd0);
        checkOutput("midrst_busy", 32'(get_busy(0)), 32'd0);
        checkOutput("midrst_overrun", 32'(get_overrun(0)), 32'd0);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("midrst_v%0d", k), 32'(get_v(0, k)), 32'd0);
        end
        #2;
        rst_n = 1'b0;
        tick();
        applyStimulus(mk(0, 100, 0, 0, 0, 4'b0000, 100, 0, 0, 0), 0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
